imm_decode_stage: RTL

Registered decode stage between instruction fetch and execute. It accepts one 32-bit instruction per cycle over a valid/ready handshake and classifies its opcode into an immediate format. It sign- or zero-extends the immediate to 32 bits and presents instruction, immediate, format code and an illegal flag through a two-entry skid buffer. Execute-side backpressure never creates a combinational path back to fetch.

---
 rtl/imm_decode_if.sv | 25 ++
 rtl/imm_decode_stage.sv | 132 +++++++++++++
 2 files changed

// File: rtl/imm_decode_if.sv
// Fetch -> decode -> execute handshake bundle for imm_decode_stage.
// The fetch/execute environment drives the master side; the stage uses the slave side.
interface imm_decode_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
  );
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a two-entry skid buffer (main M + skid K).
// in_ready comes straight from a flop, so execute backpressure never reaches fetch combinationally.
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  imm_decode_if.slave   bus
);
  typedef enum logic [2:0] {F_NONE, F_I, F_S, F_B, F_U, F_J, F_Z, F_C} fmt_e;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  state_e state, state_nxt;
  entry_t m_q, k_q, dec;
  logic   in_ready_q;
  logic   in_fire, load_m, load_k, move_k;

  // Combinational immediate decode of the word presented by fetch
  always_comb begin
    logic [31:0] ins;
    ins         = bus.in_instr;
    dec         = '0;
    dec.instr   = ins;
    dec.pc      = bus.in_pc;
    dec.fmt     = F_NONE;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec.fmt = F_I;
        dec.imm = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0100011: begin
        dec.fmt = F_S;
        dec.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        dec.fmt = F_B;
        dec.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = F_U;
        dec.imm = {ins[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = F_J;
        dec.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b1110011: begin
        case (ins[14:12])
          3'b000:                 dec.fmt = F_NONE;
          3'b100:                 dec.illegal = 1'b1;
          3'b001, 3'b010, 3'b011: begin
            dec.fmt = F_C;
            dec.imm = {20'b0, ins[31:20]};
          end
          default: begin
            dec.fmt = F_Z;
            dec.imm = {27'b0, ins[19:15]};
          end
        endcase
      end
      7'b0110011, 7'b0001111: dec.fmt = F_NONE;
      default:                dec.illegal = 1'b1;
    endcase
  end

  // A flush discards the word offered in the same cycle even when in_ready is high
  assign in_fire = bus.in_valid && in_ready_q && !bus.flush;

  always_comb begin
    state_nxt = state;
    load_m    = 1'b0;
    load_k    = 1'b0;
    move_k    = 1'b0;
    if (bus.flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          load_m    = 1'b1;
          state_nxt = ONE;
        end
        ONE: begin
          if (bus.out_ready && in_fire) begin
            load_m = 1'b1;
          end else if (bus.out_ready) begin
            state_nxt = EMPTY;
          end else if (in_fire) begin
            load_k    = 1'b1;
            state_nxt = FULL;
          end
        end
        FULL: if (bus.out_ready) begin
          move_k    = 1'b1;
          state_nxt = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      m_q        <= '0;
      k_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
      if (load_m)      m_q <= dec;
      else if (move_k) m_q <= k_q;
      if (load_k)      k_q <= dec;
      else if (move_k) k_q <= '0;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state != EMPTY);
  assign bus.out_instr   = m_q.instr;
  assign bus.out_pc      = m_q.pc;
  assign bus.out_imm     = m_q.imm;
  assign bus.out_fmt     = m_q.fmt;
  assign bus.out_illegal = m_q.illegal;
endmodule
